// File: rtl/uart_tx_io_if.sv
// rtl/uart_tx_io_if.sv - Bus-side signal bundle of the memory-mapped UART transmitter.
interface uart_tx_io_if #(
    parameter int DW = 16,
    parameter int AW = 13
);
    logic [DW-1:0] din;
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] dout;

    modport master (output din, output addr, output we, input dout);
    modport slave  (input din, input addr, input we, output dout);
endinterface

// File: rtl/uart_tx_io.sv
// rtl/uart_tx_io.sv - Memory-mapped UART transmitter: TX FIFO, baud FSM, registered reads.
// Optional even-parity bit enabled by defining UART_PARITY_EN.
module uart_tx_io #(
    parameter int            DW      = 16,
    parameter int            AW      = 13,
    parameter int            FIFO_AW = 3,
    parameter logic [DW-1:0] DIV_RST = 16'd103
) (
    input  logic         clk,
    input  logic         rst,
    uart_tx_io_if.slave  bus,
    output logic         tx
);

`ifdef UART_PARITY_EN
    localparam logic PARITY_EN = 1'b1;
`else
    localparam logic PARITY_EN = 1'b0;
`endif

    localparam logic [FIFO_AW:0]   FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
    localparam logic [DW-1:0]      DW_ONE   = DW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t              state_q, state_d;
    logic [DW-1:0]       cnt_q, cnt_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic [7:0]          byte_q, byte_d;
    logic                tx_q, tx_d;
    logic [DW-1:0]       div_q, div_d;
    logic                ovf_q, ovf_d;
    logic [DW-1:0]       dout_q, dout_d;
    logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]    count_q, count_d;
    logic [7:0]          mem_q [0:(1<<FIFO_AW)-1];
    logic [7:0]          mem_d [0:(1<<FIFO_AW)-1];

    logic empty, full, busy, push, pop, bit_end, wr_data;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign busy    = (state_q != S_IDLE) || !empty;
    assign bit_end = (cnt_q == '0);
    assign wr_data = bus.we && (bus.addr == AW'(0));
    // Full is judged on the pre-edge count, so a same-cycle pop never rescues a push.
    assign push    = wr_data && !full;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        byte_d    = byte_q;
        pop       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    byte_d  = mem_q[rd_ptr_q];
                    cnt_d   = div_q;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    cnt_d     = div_q;
                    bit_idx_d = 3'd0;
                    state_d   = S_DATA;
                end else begin
                    cnt_d = cnt_q - DW_ONE;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d = div_q;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - DW_ONE;
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    cnt_d   = div_q;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q - DW_ONE;
                end
            end
`endif
            S_STOP: begin
                // A queued byte starts its frame straight from the stop bit, no idle gap.
                if (bit_end) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        byte_d  = mem_q[rd_ptr_q];
                        cnt_d   = div_q;
                        state_d = S_START;
                    end else begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - DW_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = byte_q[bit_idx_q];
`ifdef UART_PARITY_EN
            S_PARITY: tx_d = ^byte_q;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = bus.din[7:0];
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        div_d = div_q;
        ovf_d = ovf_q;
        if (wr_data && full) begin
            ovf_d = 1'b1;
        end
        if (bus.we && (bus.addr == AW'(1)) && bus.din[3]) begin
            ovf_d = 1'b0;
        end
        if (bus.we && (bus.addr == AW'(2))) begin
            div_d = bus.din;
        end
        case (bus.addr)
            AW'(1):  dout_d = {{(DW-5){1'b0}}, PARITY_EN, ovf_q, empty, full, busy};
            AW'(2):  dout_d = div_q;
            AW'(3):  dout_d = DW'(count_q);
            default: dout_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            byte_q    <= 8'd0;
            tx_q      <= 1'b1;
            div_q     <= DIV_RST;
            ovf_q     <= 1'b0;
            dout_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            byte_q    <= byte_d;
            tx_q      <= tx_d;
            div_q     <= div_d;
            ovf_q     <= ovf_d;
            dout_q    <= dout_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // FIFO storage needs no reset; the pointers and count define its contents.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.dout = dout_q;
    assign tx       = tx_q;

endmodule

// File: tb/tb_uart_tx_io.sv
// tb/tb_uart_tx_io.sv - Self-checking bench for uart_tx_io against a frame-level reference model.
module tb_uart_tx_io;

    localparam int DEPTH = 8;
`ifdef UART_PARITY_EN
    localparam int          FB   = 11;
    localparam logic [15:0] PBIT = 16'h0010;
`else
    localparam int          FB   = 10;
    localparam logic [15:0] PBIT = 16'h0000;
`endif

    logic clk = 1'b0;
    logic rst;
    logic tx;

    uart_tx_io_if #(.DW(16), .AW(13)) bus();

    uart_tx_io dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .tx  (tx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    logic [7:0] mq [$];
    logic       m_ovf      = 1'b0;
    int         m_div      = 103;
    logic       have_frame = 1'b0;
    int         f_t        = 0;
    int         f_len      = 0;
    int         f_div      = 0;
    logic [7:0] f_byte     = 8'd0;

    int tx_bad    = 0;
    int dout_bad  = 0;
    int first_bad = -1;

    // Frame bit idx: 0 start, 1..8 data LSB first, optional even parity, then stop.
    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (FB == 11 && idx == 9) return ^b;
        return 1'b1;
    endfunction

    function automatic logic m_active(input int e);
        return have_frame && (e > f_t) && (e <= f_t + f_len);
    endfunction

    function automatic logic m_idle();
        return !m_active(edge_n + 1) && (mq.size() == 0);
    endfunction

    task automatic cyc(input logic r, input logic w, input logic [12:0] a, input logic [15:0] d);
        int          e;
        logic        act;
        logic        full_pre;
        logic        exp_tx;
        logic [15:0] exp_dout;
        rst      = r;
        bus.we   = w;
        bus.addr = a;
        bus.din  = d;
        e        = edge_n + 1;
        act      = m_active(e);
        exp_tx   = act ? frame_bit(f_byte, (e - f_t - 1) / (f_div + 1)) : 1'b1;
        full_pre = (mq.size() == DEPTH);
        case (a)
            13'd1:   exp_dout = PBIT | {12'd0, m_ovf, mq.size() == 0, full_pre, act || mq.size() != 0};
            13'd2:   exp_dout = 16'(m_div);
            13'd3:   exp_dout = 16'(mq.size());
            default: exp_dout = 16'd0;
        endcase
        if (r) begin
            exp_tx     = 1'b1;
            exp_dout   = 16'd0;
            mq.delete();
            m_ovf      = 1'b0;
            m_div      = 103;
            have_frame = 1'b0;
        end else begin
            if (mq.size() != 0 && (!act || e == f_t + f_len)) begin
                f_byte     = mq.pop_front();
                f_t        = e;
                f_div      = m_div;
                f_len      = FB * (m_div + 1);
                have_frame = 1'b1;
            end
            if (w) begin
                case (a)
                    13'd0: if (full_pre) m_ovf = 1'b1; else mq.push_back(d[7:0]);
                    13'd1: if (d[3]) m_ovf = 1'b0;
                    13'd2: m_div = int'(d);
                    default: ;
                endcase
            end
        end
        @(posedge clk);
        #1;
        edge_n = e;
        if (tx !== exp_tx) begin
            tx_bad++;
            if (first_bad < 0) first_bad = edge_n;
        end
        if (bus.dout !== exp_dout) begin
            dout_bad++;
            if (first_bad < 0) first_bad = edge_n;
        end
    endtask

    task automatic wait_idle(input int budget, output logic timed_out);
        int n;
        n = 0;
        timed_out = 1'b0;
        while (!m_idle()) begin
            cyc(1'b0, 1'b0, 13'($urandom % 4), 16'd0);
            n++;
            if (n > budget) begin
                timed_out = 1'b1;
                break;
            end
        end
        cyc(1'b0, 1'b0, 13'd0, 16'd0);
    endtask

    task automatic test_reset();
        cyc(1'b1, 1'b0, 13'd0, 16'd0);
        checks++;
        if (bus.dout !== 16'd0 || tx !== 1'b1) begin
            errors++; $display("FAIL reset_state dout=%h tx=%b required dout=0000 tx=1", bus.dout, tx);
        end
        cyc(1'b0, 1'b0, 13'd1, 16'd0);
        checks++;
        if (bus.dout !== (16'h0004 | PBIT)) begin
            errors++; $display("FAIL reset_status got=%h required=%h", bus.dout, 16'h0004 | PBIT);
        end
        cyc(1'b0, 1'b0, 13'd2, 16'd0);
        checks++;
        if (bus.dout !== 16'h0067) begin
            errors++; $display("FAIL reset_div got=%h required=0067", bus.dout);
        end
        cyc(1'b0, 1'b0, 13'd3, 16'd0);
        checks++;
        if (bus.dout !== 16'h0000 || tx !== 1'b1) begin
            errors++; $display("FAIL reset_count got=%h tx=%b required=0000 tx=1", bus.dout, tx);
        end
    endtask

    task automatic test_single_frame();
        logic        wv [0:63];
        logic [15:0] st_mid, st_end;
        logic [10:0] pat;
        int          bad;
        pat = {1'b1, (FB == 11) ? 1'b0 : 1'b1, 8'hA5, 1'b0};
        st_mid = 16'd0;
        st_end = 16'd0;
        cyc(1'b0, 1'b1, 13'd2, 16'd3);
        cyc(1'b0, 1'b1, 13'd0, 16'h00A5);
        for (int k = 0; k < FB*4 + 6; k++) begin
            cyc(1'b0, 1'b0, 13'd1, 16'd0);
            wv[k] = tx;
            if (k == 20) st_mid = bus.dout;
            if (k == FB*4 + 4) st_end = bus.dout;
        end
        checks++;
        if (wv[0] !== 1'b1) begin
            errors++; $display("FAIL t2_latency tx one edge after write=%b required 1", wv[0]);
        end
        bad = 0;
        for (int k = 1; k <= FB*4 + 1; k++) begin
            if (wv[k] !== ((k <= FB*4) ? pat[(k-1)/4] : 1'b1)) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL t2_frame_bits wrong_cycles=%0d required 0", bad);
        end
        checks++;
        if (st_mid !== (16'h0005 | PBIT)) begin
            errors++; $display("FAIL t2_status_mid got=%h required=%h", st_mid, 16'h0005 | PBIT);
        end
        checks++;
        if (st_end !== (16'h0004 | PBIT)) begin
            errors++; $display("FAIL t2_status_end got=%h required=%h", st_end, 16'h0004 | PBIT);
        end
        checks++;
        if (tx_bad !== 0 || dout_bad !== 0) begin
            errors++; $display("FAIL t2_model tx_bad=%0d dout_bad=%0d first_edge=%0d required 0", tx_bad, dout_bad, first_bad);
        end
        tx_bad = 0; dout_bad = 0; first_bad = -1;
    endtask

    task automatic test_overflow();
        int   n0, busy_end;
        logic to;
        wait_idle(2000, to);
        cyc(1'b0, 1'b1, 13'd2, 16'd100);
        cyc(1'b0, 1'b1, 13'd0, 16'($urandom_range(0, 255)));
        n0 = edge_n;
        for (int i = 1; i < 10; i++) cyc(1'b0, 1'b1, 13'd0, 16'($urandom_range(0, 255)));
        cyc(1'b0, 1'b0, 13'd1, 16'd0);
        checks++;
        if (bus.dout !== (16'h000B | PBIT)) begin
            errors++; $display("FAIL t3_status_ovf got=%h required=%h", bus.dout, 16'h000B | PBIT);
        end
        cyc(1'b0, 1'b0, 13'd3, 16'd0);
        checks++;
        if (bus.dout !== 16'd8) begin
            errors++; $display("FAIL t3_count got=%h required=0008", bus.dout);
        end
        cyc(1'b0, 1'b1, 13'd1, 16'h0008);
        cyc(1'b0, 1'b0, 13'd1, 16'd0);
        checks++;
        if (bus.dout !== (16'h0003 | PBIT)) begin
            errors++; $display("FAIL t3_ovf_clear got=%h required=%h", bus.dout, 16'h0003 | PBIT);
        end
        busy_end = -1;
        for (int i = 0; i < 12000; i++) begin
            cyc(1'b0, 1'b0, 13'd1, 16'd0);
            if (bus.dout[0] === 1'b0) begin
                busy_end = edge_n;
                break;
            end
        end
        checks++;
        if (busy_end !== n0 + 2 + 9 * FB * 101) begin
            errors++; $display("FAIL t3_nine_frames busy_end_edge=%0d required=%0d", busy_end, n0 + 2 + 9 * FB * 101);
        end
        checks++;
        if (tx_bad !== 0 || dout_bad !== 0) begin
            errors++; $display("FAIL t3_model tx_bad=%0d dout_bad=%0d first_edge=%0d required 0", tx_bad, dout_bad, first_bad);
        end
        tx_bad = 0; dout_bad = 0; first_bad = -1;
    endtask

    task automatic test_back_to_back();
        logic wv [0:127];
        logic to;
        wait_idle(2000, to);
        cyc(1'b0, 1'b1, 13'd2, 16'd3);
        cyc(1'b0, 1'b1, 13'd0, 16'h0055);
        cyc(1'b0, 1'b1, 13'd0, 16'h00AA);
        for (int k = 0; k < FB*8 + 10; k++) begin
            cyc(1'b0, 1'b0, 13'd3, 16'd0);
            wv[k] = tx;
        end
        checks++;
        if (wv[0] !== 1'b0) begin
            errors++; $display("FAIL t4_first_start tx=%b required 0", wv[0]);
        end
        checks++;
        if (wv[FB*4 - 1] !== 1'b1 || wv[FB*4] !== 1'b0) begin
            errors++; $display("FAIL t4_second_start stop=%b start=%b required stop=1 start=0", wv[FB*4 - 1], wv[FB*4]);
        end
        checks++;
        if (wv[FB*4 + 4] !== 1'b0 || wv[FB*4 + 8] !== 1'b1) begin
            errors++; $display("FAIL t4_second_bits b0=%b b1=%b required b0=0 b1=1", wv[FB*4 + 4], wv[FB*4 + 8]);
        end
        checks++;
        if (tx_bad !== 0 || dout_bad !== 0) begin
            errors++; $display("FAIL t4_model tx_bad=%0d dout_bad=%0d first_edge=%0d required 0", tx_bad, dout_bad, first_bad);
        end
        tx_bad = 0; dout_bad = 0; first_bad = -1;
    endtask

    task automatic test_reset_midframe();
        int   n0, lows;
        logic to;
        wait_idle(2000, to);
        cyc(1'b0, 1'b1, 13'd2, 16'd7);
        cyc(1'b0, 1'b1, 13'd0, 16'h00C3);
        n0 = edge_n;
        cyc(1'b0, 1'b1, 13'd0, 16'h0011);
        cyc(1'b0, 1'b1, 13'd0, 16'h0022);
        while (edge_n < n0 + 36) cyc(1'b0, 1'b0, 13'd0, 16'd0);
        cyc(1'b1, 1'b0, 13'd0, 16'd0);
        checks++;
        if (tx !== 1'b1) begin
            errors++; $display("FAIL t5_tx_after_rst tx=%b required 1", tx);
        end
        cyc(1'b0, 1'b0, 13'd1, 16'd0);
        checks++;
        if (bus.dout !== (16'h0004 | PBIT)) begin
            errors++; $display("FAIL t5_status got=%h required=%h", bus.dout, 16'h0004 | PBIT);
        end
        cyc(1'b0, 1'b0, 13'd2, 16'd0);
        checks++;
        if (bus.dout !== 16'h0067) begin
            errors++; $display("FAIL t5_div got=%h required=0067", bus.dout);
        end
        lows = 0;
        for (int i = 0; i < 300; i++) begin
            cyc(1'b0, 1'b0, 13'd3, 16'd0);
            if (tx !== 1'b1) lows++;
        end
        checks++;
        if (lows !== 0) begin
            errors++; $display("FAIL t5_no_frames low_cycles=%0d required 0", lows);
        end
        tx_bad = 0; dout_bad = 0; first_bad = -1;
    endtask

    task automatic test_random();
        logic [12:0] um [0:3];
        logic        to;
        int          timeouts, nb, gap, op;
        um[0] = 13'd4; um[1] = 13'h1000; um[2] = 13'h0402; um[3] = 13'h1FFF;
        timeouts = 0;
        for (int r = 0; r < 6; r++) begin
            wait_idle(20000, to);
            if (to) timeouts++;
            cyc(1'b0, 1'b1, 13'd2, (r == 0) ? 16'd0 : 16'($urandom_range(1, 4)));
            nb = $urandom_range(1, 11);
            for (int i = 0; i < nb; i++) begin
                gap = $urandom_range(0, 3);
                for (int g = 0; g < gap; g++) begin
                    op = $urandom_range(0, 7);
                    if (op == 0)      cyc(1'b0, 1'b1, 13'd1, 16'($urandom));
                    else if (op == 1) cyc(1'b0, 1'b1, um[$urandom_range(0, 3)], 16'($urandom));
                    else if (op == 2) cyc(1'b0, 1'b0, um[$urandom_range(0, 3)], 16'd0);
                    else              cyc(1'b0, 1'b0, 13'($urandom_range(0, 3)), 16'd0);
                end
                cyc(1'b0, 1'b1, 13'd0, 16'($urandom));
            end
        end
        wait_idle(20000, to);
        if (to) timeouts++;
        checks++;
        if (timeouts !== 0) begin
            errors++; $display("FAIL rnd_timeout count=%0d required 0", timeouts);
        end
        checks++;
        if (tx_bad !== 0) begin
            errors++; $display("FAIL rnd_tx_wave mismatches=%0d first_edge=%0d required 0", tx_bad, first_bad);
        end
        checks++;
        if (dout_bad !== 0) begin
            errors++; $display("FAIL rnd_readback mismatches=%0d first_edge=%0d required 0", dout_bad, first_bad);
        end
        tx_bad = 0; dout_bad = 0; first_bad = -1;
    endtask

`ifdef UART_PARITY_EN
    task automatic test_parity();
        logic        wv [0:63];
        logic [15:0] st;
        logic        to;
        wait_idle(2000, to);
        cyc(1'b0, 1'b1, 13'd2, 16'd1);
        cyc(1'b0, 1'b1, 13'd0, 16'h0007);
        cyc(1'b0, 1'b0, 13'd1, 16'd0);
        st = bus.dout;
        for (int k = 0; k < 30; k++) begin
            cyc(1'b0, 1'b0, 13'd0, 16'd0);
            wv[k] = tx;
        end
        checks++;
        if (wv[16] !== 1'b0 || wv[18] !== 1'b1 || wv[19] !== 1'b1 || wv[20] !== 1'b1 || wv[22] !== 1'b1) begin
            errors++; $display("FAIL t6_parity bit7=%b par=%b%b stop=%b idle=%b required 0 11 1 1",
                               wv[16], wv[18], wv[19], wv[20], wv[22]);
        end
        checks++;
        if (st[4] !== 1'b1) begin
            errors++; $display("FAIL t6_status_bit4 got=%b required 1", st[4]);
        end
        checks++;
        if (tx_bad !== 0 || dout_bad !== 0) begin
            errors++; $display("FAIL t6_model tx_bad=%0d dout_bad=%0d first_edge=%0d required 0", tx_bad, dout_bad, first_bad);
        end
        tx_bad = 0; dout_bad = 0; first_bad = -1;
    endtask
`endif

    initial begin
        rst      = 1'b1;
        bus.we   = 1'b0;
        bus.addr = 13'd0;
        bus.din  = 16'd0;
        test_reset();
        test_single_frame();
        test_overflow();
        test_back_to_back();
        test_reset_midframe();
        test_random();
`ifdef UART_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
